// File: rtl/run_monitor.sv
// run_monitor: end-of-program monitor and memory dump sequencer.
//
// Taps the instruction fetch bus and counts RUN cycles until the halt word
// is fetched or the cycle budget runs out. After a halt it waits a fixed
// number of drain cycles, then reads DUMP_WORDS words of data memory through
// a synchronous read port and streams them out over valid/ready.
//
// Build option: RUN_MONITOR_DUMP_EN
//   defined   - DRAIN is followed by the memory dump (DUMP_RD/DUMP_OUT).
//   undefined - DRAIN goes straight to DONE; the dump port outputs are
//               tied to 0 and out_ready/dump_rd_data are ignored.
//
// Ports:
//   clk, reset (async, active low)     clock and reset
//   start                              begin a run (IDLE/DONE/TIMEOUT only)
//   inst_valid, inst                   fetch bus tap
//   dump_rd_en, dump_addr              DMEM read strobe and word address
//   dump_rd_data                       DMEM read data, one cycle after strobe
//   out_valid, out_ready               dump stream handshake
//   out_data, out_index                dumped word and its address
//   busy, done, timeout                status (RUN..DUMP / DONE / TIMEOUT)
//   cycle_count                        RUN cycle count, frozen after halt
//
// state    | meaning
// IDLE     | waiting for start after reset
// RUN      | program executing, counting cycles, watching for halt
// DRAIN    | halt seen, letting the pipeline settle
// DUMP_RD  | read strobe issued for dump_addr
// DUMP_OUT | word presented on the output, waiting for out_ready
// DONE     | dump complete (sticky until start)
// TIMEOUT  | cycle budget exhausted without halt (sticky until start)

module run_monitor #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 8,
  parameter int CNT_W          = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = '0,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int DRAIN_CYCLES   = 5,
  parameter int DUMP_WORDS     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] inst,
  output logic              dump_rd_en,
  output logic [ADDR_W-1:0] dump_addr,
  input  logic [DATA_W-1:0] dump_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD   = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE, TIMEOUT
  } state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               halt_seen;
  logic               last_word;

  assign halt_seen = inst_valid && (inst == HALT_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cycle_count <= '0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            state       <= RUN;
            cycle_count <= '0;
          end
        end
        RUN: begin
          // Halt wins over timeout when both land on the same cycle.
          if (halt_seen) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end else if (cycle_count == TIMEOUT_LAST) begin
            state <= TIMEOUT;
          end else if (cycle_count != '1) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
`ifdef RUN_MONITOR_DUMP_EN
            state <= DUMP_RD;
`else
            state <= DONE;
`endif
          end else begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
          end
        end
`ifdef RUN_MONITOR_DUMP_EN
        DUMP_RD: state <= DUMP_OUT;
        DUMP_OUT: begin
          if (out_ready) state <= last_word ? DONE : DUMP_RD;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state == RUN) || (state == DRAIN) ||
                   (state == DUMP_RD) || (state == DUMP_OUT);
  assign done    = (state == DONE);
  assign timeout = (state == TIMEOUT);

`ifdef RUN_MONITOR_DUMP_EN
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              fresh_q;

  assign last_word = (addr_q == ADDR_W'(DUMP_WORDS - 1));

  // Read data arrives during the first DUMP_OUT cycle (fresh_q) and is only
  // guaranteed for that cycle, so it is passed straight through then and held
  // in data_q for any further cycles of back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      index_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      fresh_q <= (state == DUMP_RD);
      if (fresh_q) data_q <= dump_rd_data;
      case (state)
        IDLE, DONE, TIMEOUT: begin
          if (start) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
          end
        end
        DUMP_RD: begin
          valid_q <= 1'b1;
          index_q <= addr_q;
        end
        DUMP_OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            if (!last_word) addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dump_rd_en = (state == DUMP_RD);
  assign dump_addr  = addr_q;
  assign out_valid  = valid_q;
  assign out_index  = index_q;
  assign out_data   = fresh_q ? dump_rd_data : data_q;
`else
  logic unused_dump;

  assign last_word   = 1'b0;
  assign unused_dump = ^{out_ready, dump_rd_data, last_word, ADDR_W'(DUMP_WORDS - 1)};
  assign dump_rd_en  = 1'b0;
  assign dump_addr   = '0;
  assign out_valid   = 1'b0;
  assign out_index   = '0;
  assign out_data    = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 8;
  localparam int CNT_W          = 32;
  localparam logic [DATA_W-1:0] HALT_WORD = 32'h0;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int DRAIN_CYCLES   = 5;
  localparam int DUMP_WORDS     = 8;

  logic              clk;
  logic              reset;
  logic              start;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              dump_rd_en;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;

  logic [DATA_W-1:0] mem [256];

  run_monitor #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .HALT_WORD(HALT_WORD),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES),
    .DUMP_WORDS(DUMP_WORDS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .inst_valid(inst_valid),
    .inst(inst), .dump_rd_en(dump_rd_en), .dump_addr(dump_addr),
    .dump_rd_data(dump_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy), .done(done),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data valid only in the cycle after the strobe,
  // garbage otherwise so a late or early capture shows up.
  always @(posedge clk) dump_rd_data <= dump_rd_en ? mem[dump_addr] : $urandom();

  always @(negedge clk) if (dump_rd_en) rd_count <= rd_count + 1;

  typedef struct {
    int halt_at;     // RUN cycle carrying HALT_WORD (0 = never)
    bit hv;          // inst_valid on that cycle
    int stall_word;  // word held with out_ready low (-1 = none)
    int stall_len;
    int reset_word;  // word at which reset hits mid-dump (-1 = none)
    bit exp_to;
    int exp_cnt;
  } vec_t;

  vec_t vecs [8];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_ctrl", {busy, done, timeout, dump_rd_en, out_valid}, 0);
    check("rst_count", cycle_count, 0);
    check("rst_data", {dump_addr, out_index, out_data}, 0);
    out_ready = 1'b0; start = 1'b0; inst_valid = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic run_case(input int halt_at, input bit hv, input int stall_word,
                          input int stall_len, input int reset_word,
                          input bit exp_to, input int exp_cnt);
    int bad;
    int rd_before;
    int end_n;
    logic [DATA_W-1:0] exp_words [$];
    for (int i = 0; i < DUMP_WORDS; i++) begin
      mem[i] = $urandom();
      exp_words.push_back(mem[i]);
    end
    rd_before = rd_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_count", cycle_count, 0);
    check("start_flags", {done, timeout, out_valid}, 0);

    end_n = exp_to ? TIMEOUT_CYCLES : halt_at;
    bad = 0;
    for (int n = 1; n <= end_n; n++) begin
      if (!busy || timeout || done) bad++;
      start = (n == 3);
      if (n == halt_at) begin
        inst_valid = hv;
        inst = HALT_WORD;
      end else begin
        inst_valid = 1'($urandom_range(0, 1));
        inst = ($urandom_range(0, 3) == 0) ? HALT_WORD : ($urandom() | 32'h1);
        if (inst == HALT_WORD) inst_valid = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    inst_valid = 1'b0;
    check("run_cycles", bad, 0);
    check("run_count", cycle_count, exp_cnt);

    if (exp_to) begin
      check("timeout_flag", {busy, done, timeout}, 3'b001);
      repeat (3) begin
        inst_valid = 1'b1; inst = HALT_WORD; tick();
      end
      inst_valid = 1'b0;
      check("timeout_sticky", {busy, done, timeout}, 3'b001);
      check("timeout_count", cycle_count, exp_cnt);
      check("timeout_no_read", rd_count - rd_before, 0);
      return;
    end

    check("halt_flags", {busy, done, timeout}, 3'b100);
    bad = 0;
    for (int k = 1; k <= DRAIN_CYCLES; k++) begin
      if (dump_rd_en || !busy) bad++;
      out_ready = 1'($urandom_range(0, 1));
      start = (k == 2);
`ifndef RUN_MONITOR_DUMP_EN
      if (reset_word >= 0 && k == 3) begin
        do_reset();
        return;
      end
`endif
      tick();
    end
    start = 1'b0;
    check("drain", bad, 0);

`ifdef RUN_MONITOR_DUMP_EN
    for (int w = 0; w < DUMP_WORDS; w++) begin
      check("rd_strobe", {dump_rd_en, out_valid}, 2'b10);
      check("rd_addr", dump_addr, w);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      check("out_valid", out_valid, 1);
      check("out_index", out_index, w);
      check("out_data", out_data, exp_words[w]);
      if (w == reset_word) begin
        do_reset();
        return;
      end
      if (w == stall_word) begin
        out_ready = 1'b0;
        bad = 0;
        repeat (stall_len) begin
          tick();
          if (!out_valid || out_index != w || out_data != exp_words[w] ||
              dump_addr != w || dump_rd_en) bad++;
        end
        check("stall_hold", bad, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("dump_end", {busy, done, timeout, out_valid}, 4'b0100);
    check("dump_reads", rd_count - rd_before, DUMP_WORDS);
`else
    check("done_nodump", {busy, done, timeout}, 3'b010);
    check("nodump_outs", {dump_rd_en, out_valid, dump_addr, out_index, out_data}, 0);
    check("nodump_reads", rd_count - rd_before, 0);
`endif

    repeat (3) begin
      inst_valid = 1'b1; inst = HALT_WORD; out_ready = 1'b1; tick();
    end
    inst_valid = 1'b0;
    out_ready = 1'b0;
    check("done_sticky", {busy, done, timeout}, 3'b010);
    check("count_frozen", cycle_count, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{12,  1, -1, 0, -1, 0, 11};
    vecs[1] = '{0,   0, -1, 0, -1, 1, 99};
    vecs[2] = '{100, 1, -1, 0, -1, 0, 99};
    vecs[3] = '{12,  1,  3, 4, -1, 0, 11};
    vecs[4] = '{50,  0, -1, 0, -1, 1, 99};
    vecs[5] = '{1,   1, -1, 0, -1, 0, 0};
    vecs[6] = '{12,  1, -1, 0,  5, 0, 11};
    vecs[7] = '{20,  1, -1, 0, -1, 0, 19};

    reset = 1'b0; start = 1'b0; inst_valid = 1'b0; inst = '0; out_ready = 1'b0;
    #7;
    check("reset_ctrl", {busy, done, timeout, dump_rd_en, out_valid}, 0);
    check("reset_count", cycle_count, 0);
    check("reset_data", {dump_addr, out_index, out_data}, 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++)
      run_case(vecs[i].halt_at, vecs[i].hv, vecs[i].stall_word, vecs[i].stall_len,
               vecs[i].reset_word, vecs[i].exp_to, vecs[i].exp_cnt);

    // Random runs against the outcome rule: a valid halt within the budget
    // freezes the count at (halt cycle - 1), otherwise the run times out.
    for (int r = 0; r < 6; r++) begin
      int h;
      bit v;
      bit to;
      int c;
      h  = $urandom_range(1, 110);
      v  = ($urandom_range(0, 3) != 0);
      to = !(v && h <= TIMEOUT_CYCLES);
      c  = to ? TIMEOUT_CYCLES - 1 : h - 1;
      run_case(h, v, $urandom_range(0, DUMP_WORDS - 1), $urandom_range(1, 4), -1, to, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable end-of-program monitor and memory dump sequencer for SoC regression runs. It watches the instruction fetch stream, counts execution cycles, and detects the halt word. It also enforces a cycle timeout and drains the pipeline for a fixed number of cycles. It then reads a window of data memory through a synchronous read port and streams each word out over a valid/ready interface. It sits beside the SoC core, tapping the IMEM fetch bus and a spare DMEM read port.

## Interface
- DATA_W, 32: instruction and data word width.
- ADDR_W, 8: dump word-address width.
- CNT_W, 32: cycle counter width.
- HALT_WORD, 32'h0: fetched instruction value that marks program completion.
- TIMEOUT_CYCLES, 100: RUN cycles allowed before timeout; must be ≥1.
- DRAIN_CYCLES, 5: cycles waited after halt before dumping; must be ≥1.
- DUMP_WORDS, 8: number of words dumped, from address 0 to DUMP_WORDS-1; must be ≤2^ADDR_W.

- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- start  in  1  begin a run; sampled in IDLE, DONE, TIMEOUT; ignored otherwise.
- inst_valid  in  1  fetch bus carries a valid instruction this cycle.
- inst  in  DATA_W  fetched instruction.
- dump_rd_en  out  1  DMEM read strobe.
- dump_addr  out  ADDR_W  DMEM word address.
- dump_rd_data  in  DATA_W  DMEM read data; valid exactly 1 cycle after dump_rd_en.
- out_valid  out  1  out_data/out_index hold a dumped word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  dumped word.
- out_index  out  ADDR_W  address of the dumped word.
- busy  out  1  state is RUN, DRAIN or DUMP.
- done  out  1  state is DONE.
- timeout  out  1  state is TIMEOUT.
- cycle_count  out  CNT_W  RUN cycle count; frozen after halt.

## Operation
- States: IDLE, RUN, DRAIN, DUMP_RD, DUMP_OUT, DONE, TIMEOUT.
- IDLE/DONE/TIMEOUT with start=1:
  - go to RUN.
  - clear cycle_count, dump_addr, out_valid, timeout.
- RUN, evaluated each cycle:
  - inst_valid=1 and inst==HALT_WORD: go to DRAIN; cycle_count not incremented (frozen); load drain counter with DRAIN_CYCLES-1.
  - else, cycle_count==TIMEOUT_CYCLES-1: go to TIMEOUT.
  - else: cycle_count+1, saturating at all-ones.
  - Halt takes priority over timeout in the same cycle.
- DRAIN: decrement the drain counter each cycle; at 0, go to DUMP_RD.
- DUMP_RD:
  - assert dump_rd_en for one cycle at the current dump_addr.
  - next state DUMP_OUT.
  - capture dump_rd_data into out_data on the following edge.
  - set out_index=dump_addr and out_valid=1.
- DUMP_OUT:
  - hold out_valid, out_data and out_index stable until out_ready=1.
  - on the accept edge, clear out_valid.
  - if dump_addr==DUMP_WORDS-1, go to DONE; else dump_addr+1 and go to DUMP_RD.
- DONE/TIMEOUT are sticky until start or reset.
- Reset at any time, including mid-dump with out_valid high:
  - state IDLE; all outputs 0; counters 0.
  - any pending word is discarded.

## Timing
- Reset values: dump_rd_en, dump_addr, out_valid, out_data, out_index, busy, done, timeout, cycle_count all 0.
- start→RUN: 1 cycle; busy rises on the edge after start.
- Halt seen on the Nth RUN cycle (first = 1) ⇒ cycle_count = N-1.
- No halt: TIMEOUT entered after exactly TIMEOUT_CYCLES RUN cycles.
- Halt→first dump_rd_en: DRAIN_CYCLES+1 cycles.
- dump_rd_en→out_valid: 1 cycle.
- Per word with out_ready held high: 2 cycles; full dump: 2·DUMP_WORDS cycles.
- out_ready while out_valid=0 has no effect.
- inst and inst_valid are ignored outside RUN.

## Configuration
- RUN_MONITOR_DUMP_EN defined:
  - DUMP_RD/DUMP_OUT are present as described above.
- RUN_MONITOR_DUMP_EN undefined:
  - DRAIN goes directly to DONE.
  - dump_rd_en, dump_addr, out_valid, out_data and out_index are tied to 0.
  - out_ready and dump_rd_data are ignored.

## Test plan
- Defaults; start, then HALT_WORD valid on RUN cycle 12 → cycle_count=11; first dump_rd_en 6 cycles after the halt; words 0..7 emitted in order; done=1 after the 8th accept.
- No halt for 100 RUN cycles → timeout=1 on cycle 101, busy=0, no dump_rd_en ever.
- Halt on RUN cycle 100 → DRAIN taken, timeout stays 0, cycle_count=99.
- out_ready held low 4 cycles on word 3 → out_data and out_index=3 stable; dump_addr frozen; no extra dump_rd_en.
- reset driven low while in DUMP_OUT at index 5 → all outputs 0 asynchronously; new start → clean run from cycle_count=0.
- HALT_WORD present but inst_valid=0 → no halt detected; start pulsed during RUN → ignored.
